sum_accumulator: RTL and testbench

//  Downstream consumer of the registered 4-bit signed adder's 5-bit sum C.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/sum_accumulator_sat_add.sv | 28 ++
 rtl/sum_accumulator.sv | 82 ++++++++
 tb/tb_sum_accumulator.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and saturation-limit helpers for the adder-sum accumulator slice.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 5;
  localparam int ACC_W_DEF = 8;
  localparam int COUNT_DEF = 4;

  function automatic int smax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int smin(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Combinational signed add of a narrow sample into a wider accumulator, clamped to ACC_W.
module sat_add
  import adder_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] y,
  output logic             sat
);

  localparam logic [ACC_W-1:0] MAXV = ACC_W'(smax(ACC_W));
  localparam logic [ACC_W-1:0] MINV = ACC_W'(smin(ACC_W));

  logic [ACC_W:0] sum;

  // One guard bit is enough: |a| and |b| both fit in ACC_W bits.
  assign sum = {a[ACC_W-1], a} + {{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b};

  always_comb begin
    sat = sum[ACC_W] ^ sum[ACC_W-1];
    y   = sum[ACC_W-1:0];
    if (sat) y = sum[ACC_W] ? MINV : MAXV;
  end

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums COUNT signed samples with saturation, then holds the total for downstream.
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int COUNT = COUNT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  localparam int CW = $clog2(COUNT + 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] sum;
  logic             sum_sat;
  logic             in_fire;
  logic             out_fire;
  logic             last;

  sat_add #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (in_data),
    .y   (sum),
    .sat (sum_sat)
  );

  assign in_ready = (state != HOLD);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last     = (int'(cnt) + 1 >= COUNT);

  // acc/cnt/out_sat are zero in IDLE, so IDLE and ACCUM share the accumulate path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_fire) begin
            acc     <= sum;
            cnt     <= cnt + 1'b1;
            out_sat <= out_sat | sum_sat;
            if (last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= sum;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed scoreboard bench: default instance plus an ACC_W=6 instance for saturation cases.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       iv0, ir0, ov0, or0, os0;
  logic [4:0] id0;
  logic [7:0] od0;
  logic       iv1, ir1, ov1, or1, os1;
  logic [4:0] id1;
  logic [5:0] od1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_d0[$];
  bit exp_s0[$];
  int exp_d1[$];
  bit exp_s1[$];

  always #5 clk = ~clk;

  sum_accumulator u0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_sat(os0)
  );

  sum_accumulator #(.ACC_W(6)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sat(os1)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitors: pop on every output transfer.
  always @(negedge clk) begin
    if (!reset && ov0 && or0) begin
      if (exp_d0.size() == 0) check("u0 unexpected output", 1, 0);
      else begin
        check("u0 out_data", int'($signed(od0)), exp_d0.pop_front());
        check("u0 out_sat", int'(os0), int'(exp_s0.pop_front()));
      end
    end
    if (!reset && ov1 && or1) begin
      if (exp_d1.size() == 0) check("u1 unexpected output", 1, 0);
      else begin
        check("u1 out_data", int'($signed(od1)), exp_d1.pop_front());
        check("u1 out_sat", int'(os1), int'(exp_s1.pop_front()));
      end
    end
  end

  // Drive one sample, wait for its transfer, then idle for `bub` cycles.
  task automatic send(input int sel, input int v, input int bub);
    int k = 0;
    if (sel == 0) begin iv0 = 1'b1; id0 = 5'(v); end
    else begin iv1 = 1'b1; id1 = 5'(v); end
    forever begin
      @(posedge clk);
      if (sel == 0 ? ir0 : ir1) break;
      k++;
      if (k > 50) begin check("send timeout", 1, 0); break; end
    end
    #1;
    if (sel == 0) iv0 = 1'b0; else iv1 = 1'b0;
    repeat (bub) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int sel, input int a, input int b, input int c, input int d,
                       input int bub);
    send(sel, a, bub); send(sel, b, bub); send(sel, c, bub); send(sel, d, 0);
  endtask

  task automatic drain(input int sel);
    int k = 0;
    while ((sel == 0 ? exp_d0.size() : exp_d1.size()) != 0) begin
      @(posedge clk); #1;
      k++;
      if (k > 100) begin check("drain timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; iv0 = 0; id0 = 0; or0 = 1; iv1 = 0; id1 = 0; or1 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", int'(ov0), 0);
    check("reset out_data", int'(od0), 0);
    check("reset in_ready", int'(ir0), 1);
    reset = 1'b0;

    // Reset mid-stream: two samples in, then 2 reset cycles.
    send(0, 5, 0); send(0, 6, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset out_valid", int'(ov0), 0);
    check("midreset out_data", int'(od0), 0);
    check("midreset out_sat", int'(os0), 0);
    check("midreset in_ready", int'(ir0), 1);

    // -8 x4 with latency check on the last transfer.
    exp_d0.push_back(-32); exp_s0.push_back(1'b0);
    send(0, -8, 0); send(0, -8, 0); send(0, -8, 0);
    check("latency pre out_valid", int'(ov0), 0);
    send(0, -8, 0);
    check("latency post out_valid", int'(ov0), 1);
    drain(0);

    // Bubbles between samples.
    exp_d0.push_back(13); exp_s0.push_back(1'b0);
    frame(0, 7, 7, 0, -1, 2);
    drain(0);

    exp_d0.push_back(9); exp_s0.push_back(1'b0);
    frame(0, -5, 3, 12, -1, 0);
    drain(0);

    // Saturation on the narrow instance.
    exp_d1.push_back(-32); exp_s1.push_back(1'b1);
    frame(1, -16, -16, -16, -16, 0);
    drain(1);
    exp_d1.push_back(31); exp_s1.push_back(1'b1);
    frame(1, 14, 14, 14, 14, 1);
    drain(1);

    // Backpressure in HOLD with in_valid asserted.
    or0 = 1'b0;
    frame(0, 10, -3, 2, 1, 0);
    iv0 = 1'b1; id0 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp out_data stable", int'($signed(od0)), 10);
      check("bp in_ready", int'(ir0), 0);
      check("bp out_valid", int'(ov0), 1);
    end
    @(posedge clk); #1;
    iv0 = 1'b0;
    exp_d0.push_back(10); exp_s0.push_back(1'b0);
    or0 = 1'b1;
    drain(0);
    exp_d0.push_back(-3); exp_s0.push_back(1'b0);
    frame(0, 2, 2, 2, -9, 0);
    drain(0);

    // Reset while holding a pending total.
    or0 = 1'b0;
    frame(0, 4, 4, 4, 4, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("hold reset out_valid", int'(ov0), 0);
    or0 = 1'b1;

    // Partial frame discarded by reset.
    send(0, 3, 0); send(0, 3, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_d0.push_back(4); exp_s0.push_back(1'b0);
    frame(0, 1, 1, 1, 1, 0);
    drain(0);

    check("u0 queue empty", exp_d0.size(), 0);
    check("u1 queue empty", exp_d1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
